udp_tx_machine: RTL and testbench

UDP/IPv4 frame builder on the MAC TX side of `eth`, the transmit counterpart of `udp_machine`. A client pushes 32-bit payload words, then commits; the block computes the IPv4 header checksum and requests a transmission from the MAC. While the frame is sent it serves bytes by MAC-driven address. Preamble, SFD and FCS are generated by the MAC. TX-port sharing with `arp_machine` is handled by an external mux and is out of scope.

---
 rtl/eth_pkg.sv | 21 ++
 rtl/ip_csum_acc.sv | 33 +++
 rtl/udp_tx_machine.sv | 190 +++++++++++++++++++
 tb/tb_udp_tx_machine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and the UDP transmit FSM state type.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned IP_HDR_LEN    = 20;
  localparam int unsigned UDP_HDR_LEN   = 8;
  localparam int unsigned ETH_MIN_FRAME = 60;
  localparam int unsigned HDR_LEN       = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StCsum,
    StReq,
    StSend
  } tx_state_e;

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement 16-bit accumulator with end-around carry folded on every add.
// csum_o is the inverted sum, ready to drop into an IPv4 header.
module ip_csum_acc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] data_i,
  output logic [15:0] csum_o
);

  logic [15:0] acc_q, acc_d;
  logic [16:0] sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, data_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      // Folding the carry back in cannot overflow again: max is 0xfffe + 1.
      acc_d = sum[15:0] + {15'd0, sum[16]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign csum_o = ~acc_q;

endmodule

// File: rtl/udp_tx_machine.sv
// UDP/IPv4 frame builder: buffers payload words, checksums the IP header, requests
// a MAC transmission and then serves frame bytes combinationally by tx_addr.
module udp_tx_machine
  import eth_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 64,
  parameter logic [47:0] LOCAL_MAC     = 48'h985aebdd1c65,
  parameter logic [31:0] LOCAL_IP      = 32'hc0a80205
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic        tx_udp_dvld,
  input  logic [31:0] tx_udp_data,
  input  logic        tx_udp_send,
  output logic        tx_udp_ready,
  output logic        tx_udp_ovf,
  output logic        tx_vld,
  output logic [10:0] tx_count,
  input  logic [10:0] tx_addr,
  output logic [7:0]  tx_data,
  input  logic        tx_adv,
  input  logic        tx_last,
  input  logic        tx_busy
);

  localparam int unsigned WcntW = $clog2(PAYLOAD_WORDS + 1);
  localparam int unsigned IdxW  = $clog2(PAYLOAD_WORDS);

  tx_state_e         state_q, state_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d, wcnt_eff;
  logic [15:0]       ident_q, ident_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [10:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [47:0]       dst_mac_q;
  logic [31:0]       dst_ip_q;
  logic [15:0]       src_port_q, dst_port_q;
  logic [31:0]       pay_mem [PAYLOAD_WORDS];

  logic              accept, wr_en, commit, latch, csum_clr, csum_add;
  logic [10:0]       pay_len, frame_eff, hdr_end, off;
  logic [15:0]       ip_len, udp_len, csum, csum_hw;
  logic [335:0]      hdr;
  logic [5:0]        hsel;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign accept    = (state_q == StIdle) || (state_q == StFill);
  assign wr_en     = accept && tx_udp_dvld && (wcnt_q != WcntW'(PAYLOAD_WORDS));
  assign wcnt_eff  = wcnt_q + {{(WcntW-1){1'b0}}, wr_en};
  // A word arriving with the commit pulse counts, so an IDLE commit with dvld is valid.
  assign commit    = accept && tx_udp_send && (wcnt_eff != '0);
  assign pay_len   = 11'({wcnt_q, 2'b00});
  assign frame_eff = 11'(HDR_LEN) + 11'({wcnt_eff, 2'b00});
  assign hdr_end   = 11'(HDR_LEN) + pay_len;
  assign ip_len    = 16'(IP_HDR_LEN + UDP_HDR_LEN) + {5'd0, pay_len};
  assign udp_len   = 16'(UDP_HDR_LEN) + {5'd0, pay_len};

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ident_d  = ident_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    latch    = 1'b0;
    csum_clr = 1'b0;
    csum_add = 1'b0;
    unique case (state_q)
      StIdle, StFill: begin
        ovf_d = tx_udp_dvld && !wr_en;
        if (wr_en) begin
          wcnt_d  = wcnt_eff;
          state_d = StFill;
        end
        if (commit) begin
          state_d  = StCsum;
          cnt_d    = '0;
          latch    = 1'b1;
          csum_clr = 1'b1;
          count_d  = (frame_eff < 11'(ETH_MIN_FRAME)) ? 11'(ETH_MIN_FRAME) : frame_eff;
        end
      end
      StCsum: begin
        csum_add = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = StReq;
      end
      StReq: begin
        if (tx_busy) state_d = StSend;
      end
      StSend: begin
        if (!tx_busy) begin
          state_d = StIdle;
          wcnt_d  = '0;
          ident_d = ident_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      ident_q    <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      dst_mac_q  <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ident_q <= ident_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (latch) begin
        dst_mac_q  <= dst_mac;
        dst_ip_q   <= dst_ip;
        src_port_q <= src_port;
        dst_port_q <= dst_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pay_mem[wcnt_q[IdxW-1:0]] <= tx_udp_data;
  end

  // IPv4 header halfwords in wire order, checksum field as zero.
  always_comb begin
    unique case (cnt_q)
      4'd0:    csum_hw = 16'h4500;
      4'd1:    csum_hw = ip_len;
      4'd2:    csum_hw = ident_q;
      4'd3:    csum_hw = 16'h4000;
      4'd4:    csum_hw = {8'h40, IP_PROTO_UDP};
      4'd6:    csum_hw = LOCAL_IP[31:16];
      4'd7:    csum_hw = LOCAL_IP[15:0];
      4'd8:    csum_hw = dst_ip_q[31:16];
      4'd9:    csum_hw = dst_ip_q[15:0];
      default: csum_hw = 16'h0000;
    endcase
  end

  ip_csum_acc u_csum (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .data_i (csum_hw),
    .csum_o (csum)
  );

  always_comb begin
    hdr = {dst_mac_q, LOCAL_MAC, ETHERTYPE_IPV4, 16'h4500, ip_len, ident_q, 16'h4000,
           8'h40, IP_PROTO_UDP, csum, LOCAL_IP, dst_ip_q, src_port_q, dst_port_q,
           udp_len, 16'h0000};
    hsel    = 6'd41 - tx_addr[5:0];
    off     = tx_addr - 11'(HDR_LEN);
    rd_word = pay_mem[off[IdxW+1:2]];
    tx_data = 8'h00;
    if (tx_addr < 11'(HDR_LEN)) begin
      tx_data = hdr[{hsel, 3'b000} +: 8];
    end else if (tx_addr < hdr_end) begin
      unique case (off[1:0])
        2'd0: tx_data = rd_word[31:24];
        2'd1: tx_data = rd_word[23:16];
        2'd2: tx_data = rd_word[15:8];
        2'd3: tx_data = rd_word[7:0];
      endcase
    end
  end

  assign unused_bits  = ^{tx_adv, tx_last, off[10:IdxW+2]};
  assign tx_udp_ready = accept;
  assign tx_udp_ovf   = ovf_q;
  assign tx_vld       = (state_q == StReq);
  assign tx_count     = count_q;

endmodule

// File: tb/tb_udp_tx_machine.sv
// Self-checking bench for udp_tx_machine: table of frames with a byte scoreboard,
// plus hand sequences for empty commit and reset during SEND.
module tb_udp_tx_machine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] dst_mac = '0;
  logic [31:0] dst_ip = '0;
  logic [15:0] src_port = '0, dst_port = '0;
  logic        tx_udp_dvld = 1'b0, tx_udp_send = 1'b0;
  logic [31:0] tx_udp_data = '0;
  logic        tx_udp_ready, tx_udp_ovf, tx_vld;
  logic [10:0] tx_count;
  logic [10:0] tx_addr = '0;
  logic [7:0]  tx_data;
  logic        tx_adv = 1'b0, tx_last = 1'b0, tx_busy = 1'b0;

  udp_tx_machine dut (
    .clk          (clk),
    .reset        (reset),
    .dst_mac      (dst_mac),
    .dst_ip       (dst_ip),
    .src_port     (src_port),
    .dst_port     (dst_port),
    .tx_udp_dvld  (tx_udp_dvld),
    .tx_udp_data  (tx_udp_data),
    .tx_udp_send  (tx_udp_send),
    .tx_udp_ready (tx_udp_ready),
    .tx_udp_ovf   (tx_udp_ovf),
    .tx_vld       (tx_vld),
    .tx_count     (tx_count),
    .tx_addr      (tx_addr),
    .tx_data      (tx_data),
    .tx_adv       (tx_adv),
    .tx_last      (tx_last),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nwords;
    bit          same_cycle;
    int          extra;
    logic [31:0] base;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [47:0] dmac;
    int          exp_count;
    int          exp_ovf;
  } vec_t;

  vec_t        vecs [6];
  int          n_tests = 0;
  int          n_fail = 0;
  int          ovf_cnt = 0;
  logic [15:0] ident_m = '0;
  logic [31:0] words_m [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap [300];

  always @(negedge clk) if (tx_udp_ovf) ovf_cnt <= ovf_cnt + 1;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] iplen, input logic [15:0] id,
                                             input logic [31:0] dip);
    logic [31:0] s;
    s = 32'h4500 + iplen + id + 32'h4000 + 32'h4011 + 32'hc0a8 + 32'h0205 +
        dip[31:16] + dip[15:0];
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int          n, total, len, flen, ovf0;
    logic [31:0] w;
    logic [15:0] iplen, udplen, cs;
    logic [7:0]  hb [42];
    logic [7:0]  b;
    words_m.delete();
    ovf0     = ovf_cnt;
    dst_mac  = v.dmac;
    dst_ip   = v.dip;
    src_port = v.sp;
    dst_port = v.dp;
    total    = v.nwords + v.extra;
    for (int k = 0; k < total; k++) begin
      w = v.base + k * 32'h04040404;
      if (words_m.size() < 64) words_m.push_back(w);
      tx_udp_data = w;
      tx_udp_dvld = 1'b1;
      if (v.same_cycle && k == total - 1) tx_udp_send = 1'b1;
      tick;
    end
    tx_udp_dvld = 1'b0;
    if (!v.same_cycle) begin
      tx_udp_send = 1'b1;
      tick;
    end
    tx_udp_send = 1'b0;

    // Scoreboard: expected bytes for the whole frame plus two bytes past the end.
    len    = 4 * words_m.size();
    flen   = (42 + len < 60) ? 60 : 42 + len;
    iplen  = 16'(28 + len);
    udplen = 16'(8 + len);
    cs     = model_csum(iplen, ident_m, v.dip);
    for (int i = 0; i < 6; i++) hb[i] = v.dmac[8*(5-i) +: 8];
    hb[6] = 8'h98; hb[7] = 8'h5a; hb[8] = 8'heb; hb[9] = 8'hdd; hb[10] = 8'h1c; hb[11] = 8'h65;
    hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[15] = 8'h00;
    hb[16] = iplen[15:8]; hb[17] = iplen[7:0]; hb[18] = ident_m[15:8]; hb[19] = ident_m[7:0];
    hb[20] = 8'h40; hb[21] = 8'h00; hb[22] = 8'h40; hb[23] = 8'h11;
    hb[24] = cs[15:8]; hb[25] = cs[7:0];
    hb[26] = 8'hc0; hb[27] = 8'ha8; hb[28] = 8'h02; hb[29] = 8'h05;
    for (int i = 0; i < 4; i++) hb[30+i] = v.dip[8*(3-i) +: 8];
    hb[34] = v.sp[15:8]; hb[35] = v.sp[7:0]; hb[36] = v.dp[15:8]; hb[37] = v.dp[7:0];
    hb[38] = udplen[15:8]; hb[39] = udplen[7:0]; hb[40] = 8'h00; hb[41] = 8'h00;
    exp_q.delete();
    for (int a = 0; a < flen + 2; a++) begin
      if (a < 42) b = hb[a];
      else if (a < 42 + len) begin
        w = words_m[(a-42)/4];
        b = w[8*(3-((a-42)%4)) +: 8];
      end else b = 8'h00;
      exp_q.push_back(b);
    end

    chk({tag, " tx_count"}, 32'(tx_count), 32'(v.exp_count));
    n = 0;
    while (!tx_vld && n < 40) begin
      if (n == 1) chk({tag, " ready_in_csum"}, 32'(tx_udp_ready), 32'd0);
      if (n == 2) begin
        tx_udp_dvld = 1'b1;
        tx_udp_data = 32'hdeadbeef;
      end
      tick;
      tx_udp_dvld = 1'b0;
      n++;
    end
    chk({tag, " vld_latency"}, 32'(n), 32'd10);

    tx_busy = 1'b1;
    tick;
    chk({tag, " vld_drop"}, 32'(tx_vld), 32'd0);
    for (int a = 0; a < v.exp_count + 2; a++) begin
      tx_addr = 11'(a);
      #1;
      cap[a] = tx_data;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk($sformatf("%s byte[%0d]", tag, a), 32'(tx_data), 32'(b));
    end
    tx_busy = 1'b0;
    tick;
    chk({tag, " ready_after"}, 32'(tx_udp_ready), 32'd1);
    chk({tag, " ovf_pulses"}, 32'(ovf_cnt - ovf0), 32'(v.exp_ovf));
    ident_m = ident_m + 16'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          seen;
    logic [31:0] w;
    vecs[0] = '{nwords: 2, same_cycle: 0, extra: 0, base: 32'h01020304, dip: 32'hc0a8014c,
                sp: 16'hea83, dp: 16'h4e50, dmac: 48'h001122334455, exp_count: 60, exp_ovf: 0};
    vecs[1] = vecs[0];
    vecs[2] = '{nwords: 5, same_cycle: 0, extra: 0, base: 32'ha1b2c3d4, dip: 32'h0a000001,
                sp: 16'h1234, dp: 16'h0035, dmac: 48'hffffffffffff, exp_count: 62, exp_ovf: 0};
    vecs[3] = '{nwords: 1, same_cycle: 1, extra: 0, base: 32'hcafef00d, dip: 32'hc0a80101,
                sp: 16'h0400, dp: 16'h0800, dmac: 48'h0a0b0c0d0e0f, exp_count: 60, exp_ovf: 0};
    vecs[4] = '{nwords: 64, same_cycle: 0, extra: 1, base: 32'h10203040, dip: 32'hac100203,
                sp: 16'hbeef, dp: 16'h1f90, dmac: 48'h02aabbccddee, exp_count: 298, exp_ovf: 1};
    vecs[5] = '{nwords: 3, same_cycle: 0, extra: 0, base: 32'h55aa00ff, dip: 32'hc0a8014c,
                sp: 16'h0001, dp: 16'h0002, dmac: 48'h665544332211, exp_count: 60, exp_ovf: 0};

    tick;
    tick;
    chk("reset tx_vld", 32'(tx_vld), 32'd0);
    chk("reset tx_count", 32'(tx_count), 32'd0);
    chk("reset ready", 32'(tx_udp_ready), 32'd1);
    chk("reset ovf", 32'(tx_udp_ovf), 32'd0);
    reset = 1'b0;
    tick;

    run_frame(vecs[0], "f0");
    chk("f0 ip_len", {16'd0, cap[16], cap[17]}, 32'h0024);
    chk("f0 ip_csum", {16'd0, cap[24], cap[25]}, 32'hb627);
    chk("f0 udp_len", {16'd0, cap[38], cap[39]}, 32'h0010);
    for (int i = 0; i < 8; i++) chk($sformatf("f0 pay[%0d]", i), 32'(cap[42+i]), 32'(i + 1));

    run_frame(vecs[1], "f1");
    chk("f1 ident", {16'd0, cap[18], cap[19]}, 32'h0001);
    chk("f1 ip_csum", {16'd0, cap[24], cap[25]}, 32'hb626);

    run_frame(vecs[2], "f2");
    run_frame(vecs[3], "f3");
    chk("f3 udp_len", {16'd0, cap[38], cap[39]}, 32'h000c);
    chk("f3 first_byte", 32'(cap[42]), 32'hca);

    run_frame(vecs[4], "f4");
    w = 32'h10203040 + 63 * 32'h04040404;
    chk("f4 last_byte", 32'(cap[297]), 32'(w[7:0]));

    // Commit with no buffered words must not start a frame.
    tx_udp_send = 1'b1;
    tick;
    tx_udp_send = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      if (tx_vld) seen = 1'b1;
      tick;
    end
    chk("empty vld_seen", 32'(seen), 32'd0);
    chk("empty ready", 32'(tx_udp_ready), 32'd1);

    // Reset while the MAC is mid-frame.
    tx_udp_data = 32'h11223344;
    tx_udp_dvld = 1'b1;
    tx_udp_send = 1'b1;
    tick;
    tx_udp_dvld = 1'b0;
    tx_udp_send = 1'b0;
    n = 0;
    while (!tx_vld && n < 40) begin
      tick;
      n++;
    end
    chk("rst vld_latency", 32'(n), 32'd10);
    tx_busy = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tx_busy = 1'b0;
    chk("rst tx_vld", 32'(tx_vld), 32'd0);
    chk("rst ready", 32'(tx_udp_ready), 32'd1);
    chk("rst tx_count", 32'(tx_count), 32'd0);
    ident_m = '0;
    tick;

    run_frame(vecs[5], "f5");
    chk("f5 ident", {16'd0, cap[18], cap[19]}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
